// File: rtl/uart_ddr_pkg.sv
// Shared constants, FSM states and the parameter check for the UART-to-DDR path.
// UART_PACK_LSB_FIRST_EN is consumed by uart_word_packer.
package uart_ddr_pkg;

  localparam int BYTE_W          = 8;
  localparam int DEF_TIMEOUT_CYC = 2048;
  localparam int DEF_FRAME_WORDS = 307200;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } pack_state_e;

  function automatic bit width_ok(int w, int b);
    return w == BYTE_W * b;
  endfunction

endpackage

// File: rtl/uart_word_packer_if.sv
// Byte stream in, FIFO write port and status pulses out.
// The master side is the byte source / FIFO; the slave side is the packer.
interface uart_word_packer_if
  import uart_ddr_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = 19
);

  logic [BYTE_W-1:0] byte_data;
  logic              byte_valid;
  logic              fifo_full;
  logic [W-1:0]      fifo_wr_data;
  logic              fifo_wr_en;
  logic              frame_done;
  logic [CNT_W-1:0]  word_cnt;
  logic              timeout_err;
  logic              overflow_err;

  modport master (
    output byte_data, byte_valid, fifo_full,
    input  fifo_wr_data, fifo_wr_en, frame_done,
    input  word_cnt, timeout_err, overflow_err
  );

  modport slave (
    input  byte_data, byte_valid, fifo_full,
    output fifo_wr_data, fifo_wr_en, frame_done,
    output word_cnt, timeout_err, overflow_err
  );

endinterface

// File: rtl/uart_pack_timeout.sv
// Idle-cycle counter for a partial word; expire fires on the
// cycle the counter sits at TIMEOUT_CYC-1 with no byte arriving.
module uart_pack_timeout
  import uart_ddr_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] cnt_q, cnt_d;

  assign expire = en && !clr &&
                  (cnt_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr || expire)
      cnt_d = '0;
    else if (en)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_word_packer.sv
// Packs UART bytes into FIFO words with timeout resync and frame counting.
// Define UART_PACK_LSB_FIRST_EN for little-endian (first byte in [7:0]) packing.
module uart_word_packer
  import uart_ddr_pkg::*;
#(
  parameter int FIFO_WR_WIDTH = 32,
  parameter int FIFO_WR_BYTE  = 4,
  parameter int TIMEOUT_CYC   = DEF_TIMEOUT_CYC,
  parameter int FRAME_WORDS   = DEF_FRAME_WORDS
) (
  input  logic               clk,
  input  logic               rst,
  uart_word_packer_if.slave  bus
);

  localparam int CNT_W = $clog2(FRAME_WORDS);
  localparam int BCW   = $clog2(FIFO_WR_BYTE + 1);
  localparam int W     = FIFO_WR_WIDTH;
  localparam int SW    = W - BYTE_W;

  if (!width_ok(FIFO_WR_WIDTH, FIFO_WR_BYTE)) begin : g_bad_width
    $error("FIFO_WR_WIDTH must equal 8*FIFO_WR_BYTE");
  end

  pack_state_e    state_q, state_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic [SW-1:0]  shift_q, shift_d;
  logic [W-1:0]   data_q, data_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic wr_en_q, wr_en_d;
  logic fd_q, fd_d;
  logic to_q, to_d;
  logic ovf_q, ovf_d;
  logic [W-1:0] packed_w;
  logic last_byte;
  logic expire;

  // shift_q holds only the bytes already received; packed_w adds the new one
`ifdef UART_PACK_LSB_FIRST_EN
  assign packed_w = {bus.byte_data, shift_q};
`else
  assign packed_w = {shift_q, bus.byte_data};
`endif

  assign last_byte = byte_cnt_q == BCW'(FIFO_WR_BYTE - 1);

  uart_pack_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (bus.byte_valid || state_q == IDLE),
    .en     (state_q == FILL && !bus.byte_valid),
    .expire (expire)
  );

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    word_cnt_d = word_cnt_q;
    wr_en_d    = 1'b0;
    fd_d       = 1'b0;
    to_d       = 1'b0;
    ovf_d      = 1'b0;
    if (bus.byte_valid) begin
`ifdef UART_PACK_LSB_FIRST_EN
      shift_d = packed_w[W-1:BYTE_W];
`else
      shift_d = packed_w[SW-1:0];
`endif
      if (last_byte) begin
        state_d    = IDLE;
        byte_cnt_d = '0;
        if (bus.fifo_full) begin
          ovf_d = 1'b1;
        end else begin
          wr_en_d = 1'b1;
          data_d  = packed_w;
          if (word_cnt_q == CNT_W'(FRAME_WORDS - 1)) begin
            word_cnt_d = '0;
            fd_d       = 1'b1;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end else begin
        state_d    = FILL;
        byte_cnt_d = byte_cnt_q + 1'b1;
      end
    end else if (expire) begin
      state_d    = IDLE;
      byte_cnt_d = '0;
      to_d       = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      word_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      fd_q       <= 1'b0;
      to_q       <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      word_cnt_q <= word_cnt_d;
      wr_en_q    <= wr_en_d;
      fd_q       <= fd_d;
      to_q       <= to_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.fifo_wr_data = data_q;
  assign bus.fifo_wr_en   = wr_en_q;
  assign bus.frame_done   = fd_q;
  assign bus.word_cnt     = word_cnt_q;
  assign bus.timeout_err  = to_q;
  assign bus.overflow_err = ovf_q;

endmodule

// File: tb/tb_uart_word_packer.sv
// Randomised and directed bench for uart_word_packer against a
// timestamp/queue reference model; FRAME_WORDS overridden to 4.
module tb_uart_word_packer;
  import uart_ddr_pkg::*;

  localparam int W  = 32;
  localparam int B  = 4;
  localparam int T  = 2048;
  localparam int F  = 4;
  localparam int CW = 2;

  logic clk;
  logic rst;

  uart_word_packer_if #(.W(W), .CNT_W(CW)) bus ();

  uart_word_packer #(
    .FIFO_WR_WIDTH (W),
    .FIFO_WR_BYTE  (B),
    .TIMEOUT_CYC   (T),
    .FRAME_WORDS   (F)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // reference model state
  byte unsigned q[$];
  int  t_now;
  int  last_t;
  logic [W-1:0] exp_data;
  int  exp_cnt;
  bit  exp_wr, exp_fd, exp_to, exp_ovf;
  int  n_wr, n_fd, n_to, n_ovf;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)",
               tag, got, exp, t_now);
    end
  endtask

  function automatic logic [W-1:0] pack_word();
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < B; i++) begin
`ifdef UART_PACK_LSB_FIRST_EN
      w = w | (W'(q[i]) << (8 * i));
`else
      w = w | (W'(q[i]) << (8 * (B - 1 - i)));
`endif
    end
    return w;
  endfunction

  task automatic model_step(input bit v, input byte unsigned d,
                            input bit f);
    exp_wr  = 0;
    exp_fd  = 0;
    exp_to  = 0;
    exp_ovf = 0;
    if (v) begin
      q.push_back(d);
      last_t = t_now;
      if (q.size() == B) begin
        if (f) begin
          exp_ovf = 1;
        end else begin
          exp_wr   = 1;
          exp_data = pack_word();
          exp_cnt  = (exp_cnt + 1) % F;
          exp_fd   = (exp_cnt == 0);
        end
        q.delete();
      end
    end else if (q.size() > 0 && t_now - last_t == T) begin
      exp_to = 1;
      q.delete();
    end
  endtask

  task automatic cyc(input bit v, input byte unsigned d, input bit f);
    bus.byte_valid = v;
    bus.byte_data  = d;
    bus.fifo_full  = f;
    model_step(v, d, f);
    @(posedge clk);
    #1;
    t_now++;
    check("fifo_wr_en", 64'(bus.fifo_wr_en), 64'(exp_wr));
    check("fifo_wr_data", 64'(bus.fifo_wr_data), 64'(exp_data));
    check("word_cnt", 64'(bus.word_cnt), 64'(exp_cnt));
    check("frame_done", 64'(bus.frame_done), 64'(exp_fd));
    check("timeout_err", 64'(bus.timeout_err), 64'(exp_to));
    check("overflow_err", 64'(bus.overflow_err), 64'(exp_ovf));
    n_wr  += int'(bus.fifo_wr_en);
    n_fd  += int'(bus.frame_done);
    n_to  += int'(bus.timeout_err);
    n_ovf += int'(bus.overflow_err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 8'h00, 0);
  endtask

  task automatic do_reset();
    bus.byte_valid = 0;
    bus.byte_data  = '0;
    bus.fifo_full  = 0;
    #2;
    rst = 1;
    @(posedge clk);
    #1;
    check("rst_wr_en", 64'(bus.fifo_wr_en), 64'd0);
    check("rst_wr_data", 64'(bus.fifo_wr_data), 64'd0);
    check("rst_word_cnt", 64'(bus.word_cnt), 64'd0);
    check("rst_flags", 64'({bus.frame_done, bus.timeout_err,
                           bus.overflow_err}), 64'd0);
    rst = 0;
    q.delete();
    exp_data = '0;
    exp_cnt  = 0;
    last_t   = t_now;
  endtask

  logic [W-1:0] w_exp;
  int s_wr, s_to, s_ovf, s_fd;
  int gap;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    t_now    = 0;
    n_wr = 0; n_fd = 0; n_to = 0; n_ovf = 0;
    rst = 0;
    do_reset();

    // spaced bytes at the real UART byte period
    s_wr = n_wr;
    cyc(1, 8'h11, 0); idle(542);
    cyc(1, 8'h22, 0); idle(542);
    cyc(1, 8'h33, 0); idle(542);
    cyc(1, 8'h44, 0);
`ifdef UART_PACK_LSB_FIRST_EN
    w_exp = 32'h44332211;
`else
    w_exp = 32'h11223344;
`endif
    check("t1_wr_en", 64'(bus.fifo_wr_en), 64'd1);
    check("t1_data", 64'(bus.fifo_wr_data), 64'(w_exp));
    check("t1_word_cnt", 64'(bus.word_cnt), 64'd1);
    idle(3);
    check("t1_one_write", 64'(n_wr - s_wr), 64'd1);

    // partial word abandoned by timeout, then a clean word
    s_to = n_to;
    cyc(1, 8'hAA, 0);
    cyc(1, 8'hBB, 0);
    idle(T);
    check("t2_timeout", 64'(n_to - s_to), 64'd1);
    for (int i = 1; i <= 4; i++) cyc(1, 8'(i), 0);
`ifdef UART_PACK_LSB_FIRST_EN
    w_exp = 32'h04030201;
`else
    w_exp = 32'h01020304;
`endif
    check("t2_data", 64'(bus.fifo_wr_data), 64'(w_exp));
    idle(2);

    // dropped word on full FIFO
    s_ovf = n_ovf;
    s_wr  = n_wr;
    cyc(1, 8'h50, 0); cyc(1, 8'h51, 0); cyc(1, 8'h52, 0);
    cyc(1, 8'h53, 1);
    check("t3_overflow", 64'(bus.overflow_err), 64'd1);
    check("t3_no_wr", 64'(n_wr - s_wr), 64'd0);
    check("t3_cnt_hold", 64'(bus.word_cnt), 64'd2);
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'h60 + i), 0);
    check("t3_next_wr", 64'(n_wr - s_wr), 64'd1);
    check("t3_ovf_once", 64'(n_ovf - s_ovf), 64'd1);

    // one full frame back-to-back
    do_reset();
    s_wr = n_wr;
    s_fd = n_fd;
    for (int i = 0; i < 4 * F; i++) begin
      cyc(1, 8'($urandom), 0);
      if (i == 4 * F - 1)
        check("t4_fd_with_wr", 64'({bus.frame_done, bus.fifo_wr_en}),
              64'd3);
    end
    check("t4_writes", 64'(n_wr - s_wr), 64'(F));
    check("t4_frame_done", 64'(n_fd - s_fd), 64'd1);
    check("t4_cnt_wrap", 64'(bus.word_cnt), 64'd0);

    // reset in the middle of a word
    cyc(1, 8'h01, 0); cyc(1, 8'h02, 0); cyc(1, 8'h03, 0);
    do_reset();
    cyc(1, 8'hDE, 0); cyc(1, 8'hAD, 0);
    cyc(1, 8'hBE, 0); cyc(1, 8'hEF, 0);
`ifdef UART_PACK_LSB_FIRST_EN
    w_exp = 32'hEFBEADDE;
`else
    w_exp = 32'hDEADBEEF;
`endif
    check("t5_data", 64'(bus.fifo_wr_data), 64'(w_exp));
    check("t5_word_cnt", 64'(bus.word_cnt), 64'd1);

    // byte landing exactly in the expiry cycle is accepted
    s_to = n_to;
    cyc(1, 8'hC0, 0);
    idle(T - 1);
    cyc(1, 8'hC1, 0);
    cyc(1, 8'hC2, 0);
    cyc(1, 8'hC3, 0);
`ifdef UART_PACK_LSB_FIRST_EN
    w_exp = 32'hC3C2C1C0;
`else
    w_exp = 32'hC0C1C2C3;
`endif
    check("t6_no_timeout", 64'(n_to - s_to), 64'd0);
    check("t6_data", 64'(bus.fifo_wr_data), 64'(w_exp));

    // randomised traffic around the timeout boundary
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 15))
        0:       gap = T - 2 + $urandom_range(0, 3);
        1, 2:    gap = $urandom_range(0, 40);
        default: gap = $urandom_range(0, 2);
      endcase
      idle(gap);
      cyc(1, 8'($urandom), ($urandom_range(0, 4) == 0));
    end
    idle(T + 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_word_packer.md
Name: uart_word_packer

Overview:
Upstream neighbour of the DDR write FIFO, fed by a UART byte receiver running on the 25 MHz pixel/FIFO clock.
- Assembles FIFO_WR_BYTE serial bytes into one FIFO_WR_WIDTH word and issues a single-cycle FIFO write.
- Resynchronises on inter-byte timeout and drops words when the FIFO is full.
- Counts words per frame and flags frame completion for the DDR write path.

Parameters:
FIFO_WR_WIDTH, 32, output word width; must equal 8*FIFO_WR_BYTE (elaboration error otherwise)
FIFO_WR_BYTE, 4, bytes per word
TIMEOUT_CYC, 2048, idle clocks inside a partial word before it is discarded (byte period at 460800 baud / 25 MHz is ~543 clocks)
FRAME_WORDS, 307200, words per frame (640x480)
CNT_W, $clog2(FRAME_WORDS), word counter width (derived localparam)

Ports:
clk  in  1  FIFO write clock
rst  in  1  asynchronous reset, active-high
byte_data  in  8  received UART byte
byte_valid  in  1  one-cycle strobe, byte_data valid
fifo_full  in  1  write FIFO full flag
fifo_wr_data  out  FIFO_WR_WIDTH  assembled word
fifo_wr_en  out  1  one-cycle write strobe
frame_done  out  1  one-cycle pulse on last word of frame
word_cnt  out  CNT_W  words written in current frame
timeout_err  out  1  one-cycle pulse, partial word discarded
overflow_err  out  1  one-cycle pulse, complete word dropped (FIFO full)

Behaviour:
- Reset: all outputs 0, byte_cnt 0, timeout counter 0, state IDLE. Reset mid-word discards the partial word; no strobe is emitted.
- States:
  - IDLE (byte_cnt==0): byte_valid -> load byte, byte_cnt=1, go to FILL.
  - FILL: each byte_valid shifts in the byte and increments byte_cnt. When the FIFO_WR_BYTE-th byte arrives: completion, byte_cnt=0, go to IDLE.
- Byte order: first received byte lands in [W-1:W-8], last byte in [7:0]. This matches the RGB in [31:8] and pad in [7:0] convention.
- Latency: completing byte strobe at cycle N -> fifo_wr_en=1 with fifo_wr_data valid at N+1. fifo_wr_data holds until the next completion.
- Full handling: fifo_full is sampled at cycle N, the completion cycle.
  - If fifo_full is high: no fifo_wr_en; overflow_err=1 at N+1; word_cnt unchanged; the word is lost.
- Timeout:
  - In FILL, the counter increments each cycle without byte_valid and clears on byte_valid.
  - When it reaches TIMEOUT_CYC-1: go to IDLE, byte_cnt=0, timeout_err pulses the next cycle.
  - byte_valid in the expiry cycle takes priority: the byte is accepted and the counter clears.
  - The counter is held at 0 in IDLE.
- Frame counter:
  - word_cnt increments with each fifo_wr_en.
  - On the write where word_cnt==FRAME_WORDS-1: word_cnt wraps to 0 and frame_done pulses in the same cycle as that fifo_wr_en.
  - Timeouts and overflows never alter word_cnt.
- Back-to-back: a byte_valid in the cycle after completion starts a new word normally; there are no dead cycles.
- Event independence: timeout_err, overflow_err and frame_done are mutually independent pulses.

Optional Feature:
Macro UART_PACK_LSB_FIRST_EN.
- Defined: first byte lands in [7:0] and last byte in [W-1:W-8] (little-endian packing for PC tools sending LSB first).
- Undefined: MSB-first packing as stated above.
- Timing, counters and flags are identical in both builds.

Decomposition:
- Shared package uart_ddr_pkg holds:
  - byte width constant (8)
  - state enum IDLE/FILL
  - default TIMEOUT_CYC and FRAME_WORDS
  - the FIFO_WR_WIDTH==8*FIFO_WR_BYTE check function
- One natural sub-module: uart_pack_timeout, the idle-cycle counter with clear/enable inputs and an expire output.
- Packing and frame counting stay in the top.

Test Plan:
- Bytes 0x11,0x22,0x33,0x44, one every 543 clk, fifo_full=0 -> single fifo_wr_en one clk after 4th strobe, data 0x11223344, word_cnt 1.
- Bytes 0xAA,0xBB then 2048 idle clk, then 0x01..0x04 -> timeout_err one pulse, then word 0x01020304 written; no word containing 0xAA.
- 4 bytes with fifo_full=1 at completion -> no fifo_wr_en, overflow_err pulse, word_cnt unchanged; next 4 bytes with full=0 written normally.
- FRAME_WORDS=4 override, 16 bytes back-to-back (byte_valid every clk) -> 4 writes, frame_done coincident with 4th write, word_cnt returns to 0.
- rst asserted after 3 bytes, released, then 4 bytes 0xDE,0xAD,0xBE,0xEF -> outputs 0 during reset, then word 0xDEADBEEF (0xEFBEADDE with UART_PACK_LSB_FIRST_EN).
- byte_valid exactly in timeout-expiry cycle -> no timeout_err, byte accepted as next byte of word.
